parser_input_arbiter: RTL and testbench
=======================================

# parser_input_arbiter

Packet-granular round-robin arbiter that shares the single 32-bit input port of `parser` among `NUM_SRC` packet sources. It sits directly in front of `parser` and drives its `dataIn`/`dataIn_val`/`dataIN_last` inputs. Once a source is granted, the arbiter holds the grant until that packet's last beat is accepted, so packets never interleave. It also checks each packet's beat count against the length field in the header and flags mismatches.

## Interface

**Parameters**
- `NUM_SRC`, default 4: number of requesting sources, 2..16.
- `DATA_W`, fixed 32: beat width, matching `parser`.

**Ports**
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `src_data`  in  NUM_SRC*32  source i occupies bits [32*i+31:32*i].
- `src_val`  in  NUM_SRC  per-source beat valid.
- `src_last`  in  NUM_SRC  per-source last beat of packet.
- `src_ready`  out  NUM_SRC  per-source ready; at most one bit is high.
- `dataIn`  out  32  beat to `parser`.
- `dataIn_val`  out  1  beat valid to `parser`.
- `dataIN_last`  out  1  last beat to `parser`.
- `dataIn_ready`  in  1  ready from `parser`.
- `grant_idx`  out  $clog2(NUM_SRC)  index of the owning source; valid while `grant_act`=1.
- `grant_act`  out  1  a packet is in flight.
- `length_err`  out  1  one-cycle pulse when a packet's beat count mismatches its header length.

## Operation

**States**
- IDLE, LOCKED.
- Registered: `grant_idx`, `last_ptr` (index of the most recently granted source), `beat_cnt` (16-bit), `exp_beats` (15-bit).

**IDLE**
- Outputs idle: `dataIn_val`=0, `src_ready`=0.
- If any `src_val` is high, select the first requester scanning `last_ptr+1, last_ptr+2, …` modulo NUM_SRC.
- Register that index into `grant_idx`, move to LOCKED, clear `beat_cnt`.

**LOCKED**
- Combinational pass-through from the granted source g:
  - `dataIn` = src_data[g]
  - `dataIn_val` = src_val[g]
  - `dataIN_last` = src_last[g]
  - `src_ready[g]` = `dataIn_ready`; every other `src_ready` bit = 0.
- A beat is accepted when `dataIn_val` & `dataIn_ready`. On each accepted beat, `beat_cnt` increments and saturates at 0xFFFF.
- On the first beat (`beat_cnt`==0), capture the length as L = {dataIn[23:16], dataIn[31:24]} (little-endian header).
  - Set `exp_beats` = (L+3)>>2, computed at 17-bit width.
  - If the result is 0, force `exp_beats` to 1.
- On acceptance of a last beat:
  - Set `last_ptr` = g.
  - Compare `beat_cnt`+1 with `exp_beats`. On mismatch, pulse `length_err` in the next cycle.
  - The packet is still delivered unmodified; the error is a flag only.
  - Re-arbitrate in the same cycle, scanning from g+1 with g excluded, over the current `src_val`. If a requester exists, load the new `grant_idx`, clear `beat_cnt`, and stay in LOCKED. Otherwise go to IDLE.
- A single-beat packet (first beat is also last) uses the length from that same beat.

**Boundary conditions**
- Only source g is still requesting at its last beat: go to IDLE. Source g can be re-granted from IDLE next cycle, with no self back-to-back grant.
- `src_val[g]` drops mid-packet: grant is held indefinitely and `dataIn_val`=0. There is no timeout.
- `src_val`/`src_last` of non-granted sources are ignored.
- `reset` asserted mid-packet: immediately return to IDLE and clear all outputs. The partial packet is dropped; `parser` is responsible for recovery.

## Timing

**Reset values**
- `src_ready`=0, `dataIn`=0, `dataIn_val`=0, `dataIN_last`=0.
- `grant_idx`=0, `grant_act`=0, `length_err`=0.
- `last_ptr`=NUM_SRC-1, so source 0 wins the first arbitration.

**Latency and throughput**
- IDLE to first beat presented: 1 cycle after `src_val` is seen.
- Between packets while other requesters are waiting: 0 bubble cycles.
- Data path: zero-latency, purely combinational in LOCKED. `dataIn_ready` to `src_ready` is a combinational path.

**Handshake**
- AXI-stream style.
- While `dataIn_val`=1 and not accepted, the arbiter holds the beat stable because the source must hold it.
- `grant_idx` changes only on an accepted last beat or from IDLE.

**Outputs**
- `length_err` is registered: high exactly one cycle, the cycle after the offending last beat.
- `grant_act` = (state==LOCKED).

## Test plan

1. Source 0 only, 20-byte packet (header 0x1400_0C00, 5 beats), `dataIn_ready`=1 → one IDLE cycle, then 5 consecutive beats on `dataIn`; `dataIN_last` on beat 5; `length_err` stays 0.
2. Sources 0 and 1 both request 25-byte packets (7 beats each) at the same cycle → source 0's 7 beats, then source 1's 7 beats with no idle cycle between; `grant_idx` 0→1.
3. All 4 sources request continuously with 3-beat packets → grant order 0,1,2,3,0,1…; no source granted twice before the others.
4. `dataIn_ready` low for 3 cycles during beat 3 of a 39-byte packet (10 beats) → `dataIn` held stable, `src_ready` low, no beat lost or duplicated, 10 beats total.
5. Source 2 sends a header with length 44 (expects 11 beats) but asserts last on beat 9 → `length_err` high for exactly 1 cycle after beat 9; beats still forwarded.
6. `reset` asserted on beat 4 of 5 → all outputs 0 the same cycle. After release, source 0 is granted first and its new packet is forwarded correctly.

Source files
------------

// File: rtl/parser_input_arbiter_if.sv
// parser_input_arbiter_if: source-side and parser-side signal bundle of the input arbiter.
interface parser_input_arbiter_if #(
    parameter int NUM_SRC = 4
);
    localparam int IW = $clog2(NUM_SRC);
    logic [NUM_SRC*32-1:0] src_data;
    logic [NUM_SRC-1:0]    src_val;
    logic [NUM_SRC-1:0]    src_last;
    logic [NUM_SRC-1:0]    src_ready;
    logic [31:0]           dataIn;
    logic                  dataIn_val;
    logic                  dataIN_last;
    logic                  dataIn_ready;
    logic [IW-1:0]         grant_idx;
    logic                  grant_act;
    logic                  length_err;
    modport slave (
        input  src_data, src_val, src_last, dataIn_ready,
        output src_ready, dataIn, dataIn_val, dataIN_last, grant_idx, grant_act, length_err
    );
    modport master (
        output src_data, src_val, src_last, dataIn_ready,
        input  src_ready, dataIn, dataIn_val, dataIN_last, grant_idx, grant_act, length_err
    );
endinterface

// File: rtl/parser_input_arbiter.sv
// parser_input_arbiter: packet-granular round-robin arbiter in front of parser's single input port,
// flagging packets whose beat count disagrees with the header length.
module parser_input_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int DATA_W  = 32
) (
    input logic                   clk,
    input logic                   reset,
    parser_input_arbiter_if.slave bus
);
    localparam int IW = $clog2(NUM_SRC);
    typedef enum logic {IDLE, LOCKED} state_t;
    state_t        r_state;
    logic [IW-1:0] r_grant;
    logic [IW-1:0] r_last_ptr;
    logic [15:0]   r_beat_cnt;
    logic [14:0]   r_exp_beats;
    logic          r_length_err;
    logic          w_locked, w_acc, w_first, w_bad;
    logic [15:0]   w_len;
    logic [16:0]   w_exp17;
    logic [14:0]   w_exp, w_exp_cur;
    logic          w_idle_hit, w_next_hit;
    logic [IW-1:0] w_idle_idx, w_next_idx;

    // first requester after 'from' within 'span' steps; iterating backwards lets the nearest win
    function automatic logic [IW:0] pick(input logic [NUM_SRC-1:0] req, input logic [IW-1:0] from, input int span);
        logic [IW:0] res;
        int          idx;
        res = '0;
        for (int k = span; k >= 1; k--) begin
            idx = (int'(from) + k) % NUM_SRC;
            if (req[idx]) res = {1'b1, IW'(idx)};
        end
        return res;
    endfunction

    assign w_locked        = r_state == LOCKED;
    assign bus.dataIn      = w_locked ? bus.src_data[DATA_W*int'(r_grant) +: DATA_W] : '0;
    assign bus.dataIn_val  = w_locked & bus.src_val[r_grant];
    assign bus.dataIN_last = w_locked & bus.src_last[r_grant];
    assign bus.src_ready   = (w_locked & bus.dataIn_ready) ? NUM_SRC'(1) << r_grant : '0;
    assign bus.grant_idx   = r_grant;
    assign bus.grant_act   = w_locked;
    assign bus.length_err  = r_length_err;

    assign w_acc     = bus.dataIn_val & bus.dataIn_ready;
    assign w_first   = r_beat_cnt == 16'd0;
    assign w_len     = {bus.dataIn[23:16], bus.dataIn[31:24]};
    assign w_exp17   = ({1'b0, w_len} + 17'd3) >> 2;
    assign w_exp     = (w_exp17 == 17'd0) ? 15'd1 : w_exp17[14:0];
    // a single-beat packet must be judged against its own header
    assign w_exp_cur = w_first ? w_exp : r_exp_beats;
    assign w_bad     = ({1'b0, r_beat_cnt} + 17'd1) != {2'b0, w_exp_cur};
    assign {w_idle_hit, w_idle_idx} = pick(bus.src_val, r_last_ptr, NUM_SRC);
    assign {w_next_hit, w_next_idx} = pick(bus.src_val, r_grant, NUM_SRC - 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_grant      <= '0;
            r_last_ptr   <= IW'(NUM_SRC - 1);
            r_beat_cnt   <= '0;
            r_exp_beats  <= '0;
            r_length_err <= 1'b0;
        end else begin
            r_length_err <= 1'b0;
            if (!w_locked) begin
                if (w_idle_hit) begin
                    r_state    <= LOCKED;
                    r_grant    <= w_idle_idx;
                    r_beat_cnt <= '0;
                end
            end else if (w_acc) begin
                r_beat_cnt <= (&r_beat_cnt) ? r_beat_cnt : r_beat_cnt + 16'd1;
                if (w_first) r_exp_beats <= w_exp;
                if (bus.dataIN_last) begin
                    r_last_ptr   <= r_grant;
                    r_length_err <= w_bad;
                    r_beat_cnt   <= '0;
                    if (w_next_hit) r_grant <= w_next_idx;
                    else r_state <= IDLE;
                end
            end
        end
    end
endmodule

// File: tb/tb_parser_input_arbiter.sv
// tb_parser_input_arbiter: directed scenarios plus randomized traffic, checked every cycle
// against a packet-level round-robin model.
module tb_parser_input_arbiter;
    localparam int N = 4;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    parser_input_arbiter_if #(.NUM_SRC(N)) bus();
    parser_input_arbiter #(.NUM_SRC(N), .DATA_W(32)) dut (.clk(clk), .reset(reset), .bus(bus));

    int checks = 0, errors = 0;
    logic [31:0] q [N][$];
    bit  hold [N];
    int  gap_pct = 0;
    bit  refill = 0, rnd_fill = 0;
    int  refill_nb = 0, refill_len = 0;
    int  m_owner = -1, m_last = N - 1, m_cnt = 0, m_exp = 0;
    bit  m_err = 0;
    int  cyc, n_acc, n_err, first_acc, last_acc, err_cyc;
    int  glog[$];
    bit  p_act, p_lastacc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int gl(input int i);
        return i < glog.size() ? glog[i] : -1;
    endfunction

    task automatic load_pkt(input int s, input int nb, input int len);
        logic [15:0] l;
        l = len[15:0];
        q[s].push_back({l[7:0], l[15:8], 16'($urandom)});
        for (int b = 1; b < nb; b++) q[s].push_back($urandom);
    endtask

    task automatic rand_pkt(input int s);
        int nb, sel, len;
        nb  = $urandom_range(1, 8);
        sel = $urandom_range(0, 9);
        len = sel < 7 ? 4 * (nb - 1) + $urandom_range(1, 4) : (sel == 7 ? 0 : $urandom_range(0, 40));
        load_pkt(s, nb, len);
    endtask

    task automatic clear_counts();
        cyc = 0; n_acc = 0; n_err = 0; first_acc = -1; last_acc = -1; err_cyc = -1;
        glog.delete(); p_act = 0; p_lastacc = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_src_ready", 32'(bus.src_ready), 0);
        chk("rst_dataIn", bus.dataIn, 0);
        chk("rst_dataIn_val", 32'(bus.dataIn_val), 0);
        chk("rst_dataIN_last", 32'(bus.dataIN_last), 0);
        chk("rst_grant_idx", 32'(bus.grant_idx), 0);
        chk("rst_grant_act", 32'(bus.grant_act), 0);
        chk("rst_length_err", 32'(bus.length_err), 0);
        for (int s = 0; s < N; s++) begin
            q[s].delete();
            hold[s] = 0;
        end
        m_owner = -1; m_last = N - 1; m_cnt = 0; m_exp = 0; m_err = 0;
        @(negedge clk);
        bus.src_val = '0;
        reset = 1'b0;
        clear_counts();
    endtask

    task automatic step(input bit rdy);
        logic [N-1:0]    v, l, er;
        logic [N*32-1:0] d;
        logic [31:0]     ed, h;
        logic            ev, el;
        int              g, len;
        @(negedge clk);
        for (int s = 0; s < N; s++) begin
            if (q[s].size() == 0 && refill) load_pkt(s, refill_nb, refill_len);
            else if (q[s].size() == 0 && rnd_fill && $urandom_range(0, 3) == 0) rand_pkt(s);
            if (q[s].size() == 0) begin
                hold[s] = 0;
                v[s] = 1'b0;
                d[32*s +: 32] = $urandom;
                l[s] = 1'($urandom_range(0, 1));
            end else begin
                if (!hold[s]) hold[s] = $urandom_range(0, 99) >= gap_pct;
                v[s] = hold[s];
                d[32*s +: 32] = q[s][0];
                l[s] = q[s].size() == 1;
            end
        end
        bus.src_val = v; bus.src_data = d; bus.src_last = l; bus.dataIn_ready = rdy;
        #1;
        g = m_owner;
        ev = 0; el = 0; ed = 0; er = '0;
        if (g >= 0) begin
            ev = v[g]; el = l[g]; ed = d[32*g +: 32];
            er = rdy ? N'(1) << g : '0;
            chk("grant_idx", 32'(bus.grant_idx), g);
        end
        chk("grant_act", 32'(bus.grant_act), 32'(g >= 0));
        chk("length_err", 32'(bus.length_err), 32'(m_err));
        chk("dataIn_val", 32'(bus.dataIn_val), 32'(ev));
        chk("dataIN_last", 32'(bus.dataIN_last), 32'(el));
        chk("dataIn", bus.dataIn, ed);
        chk("src_ready", 32'(bus.src_ready), 32'(er));
        if (bus.grant_act && (!p_act || p_lastacc)) glog.push_back(int'(bus.grant_idx));
        p_act = bus.grant_act;
        p_lastacc = bus.dataIn_val && rdy && bus.dataIN_last;
        if (bus.dataIn_val && rdy) begin
            n_acc++;
            if (first_acc < 0) first_acc = cyc;
            last_acc = cyc;
        end
        if (bus.length_err) begin
            n_err++;
            err_cyc = cyc;
        end
        m_err = 0;
        if (g < 0) begin
            for (int k = 1; k <= N; k++) if (m_owner < 0 && v[(m_last + k) % N]) m_owner = (m_last + k) % N;
            m_cnt = 0;
        end else if (v[g] && rdy) begin
            h = q[g].pop_front();
            hold[g] = 0;
            if (m_cnt == 0) begin
                len = int'({h[23:16], h[31:24]});
                m_exp = (len + 3) / 4;
                if (m_exp == 0) m_exp = 1;
            end
            m_cnt = m_cnt < 65535 ? m_cnt + 1 : m_cnt;
            if (q[g].size() == 0) begin
                m_err = m_cnt != m_exp;
                m_last = g;
                m_owner = -1;
                m_cnt = 0;
                for (int k = 1; k < N; k++) if (m_owner < 0 && v[(g + k) % N]) m_owner = (g + k) % N;
            end
        end
        cyc++;
    endtask

    initial begin
        int stall;
        bus.src_val = '0; bus.src_last = '0; bus.src_data = '0; bus.dataIn_ready = 1'b0;
        clear_counts();
        // single source, 20-byte packet
        do_reset();
        load_pkt(0, 5, 20);
        repeat (8) step(1);
        chk("t1_beats", n_acc, 5);
        chk("t1_first_beat_cycle", first_acc, 1);
        chk("t1_last_beat_cycle", last_acc, 5);
        chk("t1_errs", n_err, 0);
        chk("t1_grant0", gl(0), 0);
        // two sources, back-to-back 7-beat packets
        do_reset();
        load_pkt(0, 7, 25);
        load_pkt(1, 7, 25);
        repeat (18) step(1);
        chk("t2_beats", n_acc, 14);
        chk("t2_last_beat_cycle", last_acc, 14);
        chk("t2_grants", glog.size(), 2);
        chk("t2_grant0", gl(0), 0);
        chk("t2_grant1", gl(1), 1);
        chk("t2_errs", n_err, 0);
        // four sources always requesting 3-beat packets
        do_reset();
        refill = 1; refill_nb = 3; refill_len = 12;
        repeat (26) step(1);
        for (int k = 0; k < 8; k++) chk("t3_rr_order", gl(k), k % 4);
        chk("t3_grants", glog.size(), 9);
        refill = 0;
        repeat (20) step(1);
        chk("t3_errs", n_err, 0);
        // ready stall on beat 3 of a 10-beat packet
        do_reset();
        load_pkt(0, 10, 39);
        stall = 3;
        repeat (16) begin
            if (m_owner == 0 && m_cnt == 2 && stall > 0) begin
                stall--;
                step(0);
            end else step(1);
        end
        chk("t4_beats", n_acc, 10);
        chk("t4_last_beat_cycle", last_acc, 13);
        chk("t4_errs", n_err, 0);
        // length 44 header but only 9 beats from source 2
        do_reset();
        load_pkt(2, 9, 44);
        repeat (12) step(1);
        chk("t5_beats", n_acc, 9);
        chk("t5_errs", n_err, 1);
        chk("t5_err_cycle", err_cyc, 10);
        chk("t5_grant0", gl(0), 2);
        // reset during beat 4, then fresh traffic
        do_reset();
        load_pkt(0, 5, 20);
        repeat (4) step(1);
        chk("t6_beats_before_reset", n_acc, 3);
        do_reset();
        load_pkt(1, 3, 12);
        load_pkt(0, 5, 20);
        repeat (12) step(1);
        chk("t6_grant0", gl(0), 0);
        chk("t6_grant1", gl(1), 1);
        chk("t6_beats", n_acc, 8);
        chk("t6_errs", n_err, 0);
        // randomized traffic with gaps, stalls and bad lengths
        rnd_fill = 1; gap_pct = 20;
        for (int r = 0; r < 3; r++) begin
            do_reset();
            repeat (1500) step($urandom_range(0, 99) < 75);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
